// File: rtl/spi_write_arbiter_if.sv
// Requester-side write handshake for spi_write_arbiter.
//   reqN_valid  requester N has a write pending (held with payload until ready)
//   reqN_ready  write accepted in a cycle where valid&ready
//   reqN_addr   7-bit register address
//   reqN_data   8-bit write data
// master: the two requesters. slave: the arbiter.
interface spi_write_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/spi_write_arbiter.sv
// Round-robin arbiter and SPI master for two configuration requesters.
// Each accepted write becomes one 16-bit frame {1'b1, addr, data}, MSB first.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   req       requester handshake (slave modport)
//   busy      high while a frame or its guard time is in progress
//   done      one-cycle pulse when a frame completes; done_id names its requester
//   nCS/SCLK/COPI  SPI pins (SCLK idles low, data sampled on rising edges)
module spi_write_arbiter #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_GUARD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_write_arbiter_if.slave    req,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic                  nCS,
  output logic                  SCLK,
  output logic                  COPI
);

  localparam int unsigned TMAX = (CLK_DIV > CS_GUARD) ? CLK_DIV : CS_GUARD;
  localparam int unsigned TW   = $clog2(TMAX);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HI,
    LO,
    HOLD,
    GUARD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sr_q, sr_d;
  logic          rr_q, rr_d;
  logic          grant;
  logic          accept;
  logic          half_end;
  logic          guard_end;

  // Both valid: serve the one not served last; otherwise whichever is valid.
  always_comb begin
    grant          = (req.req0_valid && req.req1_valid) ? ~rr_q : req.req1_valid;
    accept         = (state_q == IDLE) && !rst && (req.req0_valid || req.req1_valid);
    req.req0_ready = accept && !grant;
    req.req1_ready = accept && grant;
    half_end       = (timer_q == TW'(CLK_DIV - 1));
    guard_end      = (timer_q == TW'(CS_GUARD - 1));
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (accept) begin
          state_d = SETUP;
          sr_d    = grant ? {1'b1, req.req1_addr, req.req1_data}
                          : {1'b1, req.req0_addr, req.req0_data};
          bit_d   = 4'd15;
          rr_d    = grant;
        end
      end
      SETUP: begin
        if (half_end) begin
          state_d = HI;
          timer_d = '0;
        end
      end
      HI: begin
        if (half_end) begin
          timer_d = '0;
          if (bit_q == 4'd0) begin
            state_d = HOLD;
          end else begin
            state_d = LO;
            bit_d   = bit_q - 4'd1;
            sr_d    = {sr_q[14:0], 1'b0};
          end
        end
      end
      LO: begin
        if (half_end) begin
          state_d = HI;
          timer_d = '0;
        end
      end
      HOLD: begin
        if (half_end) begin
          state_d = GUARD;
          timer_d = '0;
        end
      end
      GUARD: begin
        if (guard_end) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    nCS     = 1'b1;
    SCLK    = 1'b0;
    COPI    = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == GUARD) && (timer_q == '0);
    done_id = done && rr_q;
    if (state_q inside {SETUP, HI, LO, HOLD}) begin
      nCS  = 1'b0;
      SCLK = (state_q == HI);
      COPI = sr_q[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_spi_write_arbiter.sv
// Self-checking bench for spi_write_arbiter: default build plus a CLK_DIV=3/CS_GUARD=3 build.
module tb_spi_write_arbiter;
  localparam int CLK_DIV  = 4;
  localparam int CS_GUARD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_write_arbiter_if bus ();
  spi_write_arbiter_if bus3 ();
  logic busy, done, done_id, ncs, sclk, copi;
  logic busy3, done3, done_id3, ncs3, sclk3, copi3;

  spi_write_arbiter #(.CLK_DIV(CLK_DIV), .CS_GUARD(CS_GUARD)) dut (
    .clk(clk), .rst(rst), .req(bus.slave), .busy(busy), .done(done), .done_id(done_id),
    .nCS(ncs), .SCLK(sclk), .COPI(copi)
  );

  spi_write_arbiter #(.CLK_DIV(3), .CS_GUARD(3)) dut3 (
    .clk(clk), .rst(rst), .req(bus3.slave), .busy(busy3), .done(done3), .done_id(done_id3),
    .nCS(ncs3), .SCLK(sclk3), .COPI(copi3)
  );

  typedef struct { logic [6:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic id; logic [15:0] frame; } exp_t;
  typedef struct { logic id; logic [15:0] frame; int edges; int cs_len; int gap; } obs_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  wr_t  pend0[$], pend1[$];
  exp_t exp_q[$];
  obs_t obs_q[$], obs3_q[$];
  int   acc_cyc0[$];
  int   done_cnt = 0;
  logic [7:0] regs[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Requester driver: presents the head of each pending queue; an accept seen at
  // the negedge is committed at the next posedge and recorded as an expectation.
  logic acc0, acc1;
  initial begin
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    forever begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (acc0 && pend0.size() > 0) begin
        exp_q.push_back('{id: 1'b0, frame: {1'b1, pend0[0].addr, pend0[0].data}});
        acc_cyc0.push_back(cyc);
        void'(pend0.pop_front());
      end
      if (acc1 && pend1.size() > 0) begin
        exp_q.push_back('{id: 1'b1, frame: {1'b1, pend1[0].addr, pend1[0].data}});
        void'(pend1.pop_front());
      end
      if (pend0.size() > 0) begin
        bus.req0_valid = 1'b1; bus.req0_addr = pend0[0].addr; bus.req0_data = pend0[0].data;
      end else begin
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      end
      if (pend1.size() > 0) begin
        bus.req1_valid = 1'b1; bus.req1_addr = pend1[0].addr; bus.req1_data = pend1[0].data;
      end else begin
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
      end
    end
  end

  // SPI receiver model for the default build, with a small register file
  // standing in for the peripheral (addresses above 0x04 ignored).
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  logic [15:0] rx = '0;
  int          edges = 0, cs_len = 0, gap = 0, last_gap = 0;
  always @(negedge clk) begin
    if (rst) for (int i = 0; i < 5; i++) regs[i] = 8'h00;
    if (ncs) gap++;
    else if (prev_ncs) begin
      last_gap = gap; gap = 0; rx = '0; edges = 0; cs_len = 1;
    end else cs_len++;
    if (!ncs && sclk && !prev_sclk) begin
      rx = {rx[14:0], copi};
      edges++;
    end
    if (done) begin
      obs_q.push_back('{id: done_id, frame: rx, edges: edges, cs_len: cs_len, gap: last_gap});
      done_cnt++;
      if (rx[15] && rx[14:8] <= 7'd4) regs[rx[10:8]] = rx[7:0];
    end
    prev_ncs  = ncs;
    prev_sclk = sclk;
  end

  logic        prev_ncs3 = 1'b1, prev_sclk3 = 1'b0;
  logic [15:0] rx3 = '0;
  int          edges3 = 0, cs_len3 = 0;
  always @(negedge clk) begin
    if (!ncs3) begin
      if (prev_ncs3) begin rx3 = '0; edges3 = 0; cs_len3 = 1; end
      else cs_len3++;
      if (sclk3 && !prev_sclk3) begin rx3 = {rx3[14:0], copi3}; edges3++; end
    end
    if (done3) obs3_q.push_back('{id: done_id3, frame: rx3, edges: edges3, cs_len: cs_len3, gap: 0});
    prev_ncs3  = ncs3;
    prev_sclk3 = sclk3;
  end

  task automatic wait_obs(input int n);
    for (int k = 0; k < 20000 && obs_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy !== 1'b0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {ncs, sclk, copi, busy, done, done_id, bus.req0_ready, bus.req1_ready};
    tests++;
    if (got !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_outputs: got {nCS,SCLK,COPI,busy,done,done_id,rdy0,rdy1}=%b want 10000000", got);
    end
    tests++;
    if ({ncs3, sclk3, copi3, busy3} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_outputs_div3: got %b want 1000", {ncs3, sclk3, copi3, busy3});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    obs_t o;
    exp_t e;
    int   d0;
    d0 = done_cnt;
    pend0.push_back('{addr: 7'h00, data: 8'hA5});
    for (int k = 0; k < 100 && ncs !== 1'b0; k++) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_obs(1);
    wait_idle();
    tests++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      fails++;
      $display("FAIL single_count: got %0d frames / %0d accepts want 1/1", obs_q.size(), exp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (o.frame !== 16'h80A5) begin fails++; $display("FAIL single_frame: got %h want 80a5", o.frame); end
      tests++;
      if (o.frame !== e.frame || o.id !== e.id) begin
        fails++; $display("FAIL single_scoreboard: got %0d/%h want %0d/%h", o.id, o.frame, e.id, e.frame);
      end
      tests++;
      if (o.id !== 1'b0) begin fails++; $display("FAIL single_done_id: got %b want 0", o.id); end
      tests++;
      if (o.edges !== 16) begin fails++; $display("FAIL single_edges: got %0d want 16", o.edges); end
      tests++;
      if (o.cs_len !== 33 * CLK_DIV) begin
        fails++; $display("FAIL single_cs_len: got %0d want %0d", o.cs_len, 33 * CLK_DIV);
      end
    end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_arbitration();
    obs_t o;
    exp_t e;
    pulse_reset();
    pend0.push_back('{addr: 7'h01, data: 8'h11});
    pend0.push_back('{addr: 7'h02, data: 8'h22});
    pend1.push_back('{addr: 7'h03, data: 8'h33});
    pend1.push_back('{addr: 7'h04, data: 8'h44});
    wait_obs(4);
    wait_idle();
    tests++;
    if (obs_q.size() !== 4) begin fails++; $display("FAIL arb_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (o.id !== 1'(i % 2)) begin fails++; $display("FAIL arb_order[%0d]: got id %b want %0d", i, o.id, i % 2); end
      tests++;
      if (o.frame !== e.frame || o.id !== e.id) begin
        fails++; $display("FAIL arb_scoreboard[%0d]: got %0d/%h want %0d/%h", i, o.id, o.frame, e.id, e.frame);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    acc_cyc0.delete();
    pend0.push_back('{addr: 7'h02, data: 8'h0F});
    pend0.push_back('{addr: 7'h03, data: 8'hF0});
    pend0.push_back('{addr: 7'h00, data: 8'h5A});
    wait_obs(3);
    wait_idle();
    tests++;
    if (acc_cyc0.size() !== 3) begin fails++; $display("FAIL b2b_ready_pulses: got %0d want 3", acc_cyc0.size()); end
    for (int i = 1; i < acc_cyc0.size(); i++) begin
      tests++;
      if (acc_cyc0[i] - acc_cyc0[i-1] !== 1 + 33 * CLK_DIV + CS_GUARD) begin
        fails++;
        $display("FAIL b2b_accept_interval[%0d]: got %0d want %0d", i, acc_cyc0[i] - acc_cyc0[i-1], 1 + 33 * CLK_DIV + CS_GUARD);
      end
    end
    for (int i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (o.frame !== e.frame || o.id !== 1'b0) begin
        fails++; $display("FAIL b2b_frame[%0d]: got %0d/%h want 0/%h", i, o.id, o.frame, e.frame);
      end
      // High gap between frames is the guard time plus the IDLE accept cycle.
      if (i > 0) begin
        tests++;
        if (o.gap !== CS_GUARD + 1) begin
          fails++; $display("FAIL b2b_ncs_gap[%0d]: got %0d want %0d", i, o.gap, CS_GUARD + 1);
        end
      end
    end
  endtask

  task automatic test_abort();
    obs_t o;
    int   d0;
    int   k;
    d0 = done_cnt;
    pend0.push_back('{addr: 7'h02, data: 8'h5A});
    for (k = 0; k < 100 && ncs !== 1'b0; k++) @(negedge clk);
    @(negedge clk);
    for (k = 0; k < 2000 && edges < 8; k++) @(negedge clk);
    tests++;
    if (edges !== 8) begin fails++; $display("FAIL abort_reach_edge8: got %0d edges want 8", edges); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ncs, sclk, copi, busy, done} !== 5'b10000) begin
      fails++; $display("FAIL abort_outputs: got {nCS,SCLK,COPI,busy,done}=%b want 10000", {ncs, sclk, copi, busy, done});
    end
    @(posedge clk); #1 rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (200) @(negedge clk);
    tests++;
    if (done_cnt !== d0 || obs_q.size() !== 0) begin
      fails++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - d0);
    end
    pend1.push_back('{addr: 7'h03, data: 8'hC3});
    wait_obs(1);
    wait_idle();
    tests++;
    if (obs_q.size() !== 1) begin
      fails++; $display("FAIL abort_retry_count: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      void'(exp_q.pop_front());
      tests++;
      if (o.frame !== 16'h83C3 || o.id !== 1'b1 || o.edges !== 16) begin
        fails++; $display("FAIL abort_retry_frame: got id %b frame %h edges %0d want 1/83c3/16", o.id, o.frame, o.edges);
      end
    end
  endtask

  task automatic test_peripheral();
    pulse_reset();
    pend0.push_back('{addr: 7'h01, data: 8'h3C});
    pend0.push_back('{addr: 7'h04, data: 8'h80});
    pend0.push_back('{addr: 7'h05, data: 8'hFF});
    wait_obs(3);
    wait_idle();
    tests++;
    if (obs_q.size() !== 3) begin
      fails++; $display("FAIL periph_count: got %0d want 3", obs_q.size());
    end else begin
      tests++;
      if (obs_q[2].frame !== 16'h85FF) begin fails++; $display("FAIL periph_addr_unmodified: got %h want 85ff", obs_q[2].frame); end
    end
    tests++;
    if (regs[1] !== 8'h3C) begin fails++; $display("FAIL periph_en_reg_out_15_8: got %h want 3c", regs[1]); end
    tests++;
    if (regs[4] !== 8'h80) begin fails++; $display("FAIL periph_pwm_duty: got %h want 80", regs[4]); end
    tests++;
    if ({regs[0], regs[2], regs[3]} !== 24'h0) begin
      fails++; $display("FAIL periph_others: got %h want 000000", {regs[0], regs[2], regs[3]});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_div3();
    obs_t o;
    int   k;
    @(posedge clk); #1;
    bus3.req0_valid = 1'b1; bus3.req0_addr = 7'h00; bus3.req0_data = 8'hA5;
    for (k = 0; k < 100 && bus3.req0_ready !== 1'b1; k++) @(negedge clk);
    tests++;
    if (bus3.req0_ready !== 1'b1) begin fails++; $display("FAIL div3_ready: got %b want 1", bus3.req0_ready); end
    @(posedge clk); #1;
    bus3.req0_valid = 1'b0; bus3.req0_addr = '0; bus3.req0_data = '0;
    for (k = 0; k < 2000 && obs3_q.size() < 1; k++) @(negedge clk);
    tests++;
    if (obs3_q.size() !== 1) begin
      fails++; $display("FAIL div3_count: got %0d want 1", obs3_q.size());
    end else begin
      o = obs3_q.pop_front();
      tests++;
      if (o.frame !== 16'h80A5 || o.id !== 1'b0) begin
        fails++; $display("FAIL div3_frame: got %0d/%h want 0/80a5", o.id, o.frame);
      end
      tests++;
      if (o.edges !== 16 || o.cs_len !== 99) begin
        fails++; $display("FAIL div3_timing: got edges %0d cs_len %0d want 16/99", o.edges, o.cs_len);
      end
    end
  endtask

  initial begin
    bus3.req0_valid = 1'b0; bus3.req0_addr = '0; bus3.req0_data = '0;
    bus3.req1_valid = 1'b0; bus3.req1_addr = '0; bus3.req1_data = '0;
    test_reset();
    test_single();
    test_arbitration();
    test_back_to_back();
    test_abort();
    test_peripheral();
    test_div3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
